// File: rtl/tt_sweep_checker_if.sv
// Bus between the truth-table sweep checker and whoever drives the golden table,
// the function under test and the result readout.
interface tt_sweep_checker_if #(
  parameter int unsigned N = 3
);
  logic                   start;
  logic [(1 << N)-1:0]    expected;
  logic                   F;
  logic [N-1:0]           vec;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N:0]             err_cnt;
  logic [N-1:0]           first_err;
  logic                   first_err_valid;

  modport master (
    output start, expected, F,
    input  vec, busy, done, pass, err_cnt, first_err, first_err_valid
  );

  modport slave (
    input  start, expected, F,
    output vec, busy, done, pass, err_cnt, first_err, first_err_valid
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table checker: sweeps every input vector of an N-input function,
// waits SETTLE cycles per vector, then compares the output against a latched golden table.
module tt_sweep_checker #(
  parameter int unsigned N      = 3,
  parameter int unsigned SETTLE = 2
) (
  input logic              clk,
  input logic              rst,
  tt_sweep_checker_if.slave bus
);

  localparam int unsigned NumVec = 1 << N;
  localparam int unsigned CntW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e              state_q, state_d;
  logic [NumVec-1:0]   exp_q, exp_d;
  logic [N-1:0]        vec_q, vec_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N:0]          err_q, err_d;
  logic [N-1:0]        ferr_q, ferr_d;
  logic                fev_q, fev_d;
  logic                pass_q, pass_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      exp_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      fev_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      fev_q   <= fev_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    fev_d   = fev_q;
    pass_d  = pass_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StSettle;
          exp_d   = bus.expected;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ferr_d  = '0;
          fev_d   = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(SETTLE - 1)) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (bus.F != exp_q[vec_q]) begin
          err_d = err_q + (N + 1)'(1);
          if (!fev_q) begin
            ferr_d = vec_q;
            fev_d  = 1'b1;
          end
        end
        // Last vector: vec stays at all-ones until the next sweep starts.
        if (&vec_q) begin
          state_d = StDone;
          pass_d  = (err_d == '0);
        end else begin
          vec_d   = vec_q + N'(1);
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.vec             = vec_q;
  assign bus.busy            = (state_q != StIdle);
  assign bus.done            = (state_q == StDone);
  assign bus.pass            = pass_q;
  assign bus.err_cnt         = err_q;
  assign bus.first_err       = ferr_q;
  assign bus.first_err_valid = fev_q;

endmodule
